// File: rtl/param_sync_ram.sv
// Simple-dual-port synchronous RAM with selectable read latency, read-during-write
// policy and an optional post-reset zero-fill sweep.
module param_sync_ram #(
  parameter int DATA_W     = 4,
  parameter int ADDR_W     = 4,
  parameter int RD_LATENCY = 1,
  parameter int WR_FIRST   = 1,
  parameter int INIT_ZERO  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] datain,
  input  logic              read,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] dataout,
  output logic              rvalid,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {S_CLEAR, S_READY} state_t;
  localparam state_t RESET_STATE = (INIT_ZERO != 0) ? S_CLEAR : S_READY;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  logic              rd_acc;
  logic              bypass;
  logic [DATA_W-1:0] rd_word;

  logic              s1_v;
  logic [DATA_W-1:0] s1_d;

  // busy is a direct decode of the sequencer state, so it doubles as the state probe.
  assign busy = (state == S_CLEAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RESET_STATE;
      clr_cnt <= '0;
    end else if (state == S_CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == '1) begin
        state <= S_READY;
      end
    end
  end

  // The clear sweep owns the write port; user writes are dropped while busy.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = waddr;
    mem_wd = datain;
    if (state == S_CLEAR) begin
      mem_we = 1'b1;
      mem_wa = clr_cnt;
      mem_wd = '0;
    end else begin
      mem_we = write;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  assign rd_acc  = read && (state == S_READY);
  assign bypass  = (WR_FIRST != 0) && write && (waddr == raddr);
  assign rd_word = bypass ? datain : mem[raddr];

  // Idle slots carry zero data so dataout is 0 whenever rvalid is 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1_d <= '0;
    end else begin
      s1_v <= rd_acc;
      s1_d <= rd_acc ? rd_word : '0;
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic              s2_v;
      logic [DATA_W-1:0] s2_d;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_v <= 1'b0;
          s2_d <= '0;
        end else begin
          s2_v <= s1_v;
          s2_d <= s1_d;
        end
      end

      assign rvalid  = s2_v;
      assign dataout = s2_d;
    end else begin : g_lat1
      assign rvalid  = s1_v;
      assign dataout = s1_d;
    end
  endgenerate

endmodule

// File: tb/tb_param_sync_ram.sv
// Directed bench for param_sync_ram: default build, WR_FIRST=0 build,
// latency-2 8x64 build and INIT_ZERO=0 build sharing one clock and reset.
module tb_param_sync_ram;

  logic clk;
  logic rst_n;

  // Default build (a) and WR_FIRST=0 build (b) share one stimulus set.
  logic       write;
  logic [3:0] waddr;
  logic [3:0] datain;
  logic       read;
  logic [3:0] raddr;
  logic [3:0] a_dataout, b_dataout;
  logic       a_rvalid, b_rvalid, a_busy, b_busy;

  logic       c_write, c_read;
  logic [5:0] c_waddr, c_raddr;
  logic [7:0] c_datain, c_dataout;
  logic       c_rvalid, c_busy;

  logic       d_write, d_read;
  logic [3:0] d_waddr, d_raddr, d_datain, d_dataout;
  logic       d_rvalid, d_busy;

  int checks;
  int failures;

  param_sync_ram dut_a (
    .clk(clk), .rst_n(rst_n), .write(write), .waddr(waddr), .datain(datain),
    .read(read), .raddr(raddr), .dataout(a_dataout), .rvalid(a_rvalid), .busy(a_busy)
  );

  param_sync_ram #(.WR_FIRST(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .write(write), .waddr(waddr), .datain(datain),
    .read(read), .raddr(raddr), .dataout(b_dataout), .rvalid(b_rvalid), .busy(b_busy)
  );

  param_sync_ram #(.DATA_W(8), .ADDR_W(6), .RD_LATENCY(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .write(c_write), .waddr(c_waddr), .datain(c_datain),
    .read(c_read), .raddr(c_raddr), .dataout(c_dataout), .rvalid(c_rvalid), .busy(c_busy)
  );

  param_sync_ram #(.INIT_ZERO(0)) dut_d (
    .clk(clk), .rst_n(rst_n), .write(d_write), .waddr(d_waddr), .datain(d_datain),
    .read(d_read), .raddr(d_raddr), .dataout(d_dataout), .rvalid(d_rvalid), .busy(d_busy)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [3:0] wa;
    logic [3:0] wd;
    logic       rd;
    logic [3:0] ra;
    logic       ev;
    logic [3:0] ed_a;
    logic [3:0] ed_b;
  } vec_t;

  vec_t vec [14];

  // Driver tasks: inputs change 1ns after the edge, outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  initial begin
    int n;
    logic       s_rd [5];
    logic [5:0] s_ra [5];
    logic       s_ev [5];
    logic [7:0] s_ed [5];

    checks = 0;
    failures = 0;

    vec[0]  = '{1'b1, 4'd3,  4'hA, 1'b0, 4'd0,  1'b0, 4'h0, 4'h0};
    vec[1]  = '{1'b1, 4'd12, 4'h6, 1'b1, 4'd3,  1'b1, 4'hA, 4'hA};
    vec[2]  = '{1'b0, 4'd0,  4'h0, 1'b1, 4'd12, 1'b1, 4'h6, 4'h6};
    vec[3]  = '{1'b0, 4'd0,  4'h0, 1'b0, 4'd0,  1'b0, 4'h0, 4'h0};
    vec[4]  = '{1'b1, 4'd7,  4'h1, 1'b0, 4'd0,  1'b0, 4'h0, 4'h0};
    vec[5]  = '{1'b1, 4'd7,  4'hF, 1'b1, 4'd7,  1'b1, 4'hF, 4'h1};
    vec[6]  = '{1'b0, 4'd0,  4'h0, 1'b1, 4'd7,  1'b1, 4'hF, 4'hF};
    vec[7]  = '{1'b1, 4'd5,  4'h3, 1'b1, 4'd7,  1'b1, 4'hF, 4'hF};
    vec[8]  = '{1'b0, 4'd0,  4'h0, 1'b1, 4'd2,  1'b1, 4'h0, 4'h0};
    vec[9]  = '{1'b0, 4'd0,  4'h0, 1'b1, 4'd5,  1'b1, 4'h3, 4'h3};
    vec[10] = '{1'b1, 4'd0,  4'hC, 1'b1, 4'd15, 1'b1, 4'h0, 4'h0};
    vec[11] = '{1'b0, 4'd0,  4'h0, 1'b1, 4'd0,  1'b1, 4'hC, 4'hC};
    vec[12] = '{1'b1, 4'd15, 4'h5, 1'b1, 4'd15, 1'b1, 4'h5, 4'h0};
    vec[13] = '{1'b0, 4'd0,  4'h0, 1'b0, 4'd0,  1'b0, 4'h0, 4'h0};

    rst_n = 1'b0;
    write = 1'b0; waddr = '0; datain = '0; read = 1'b0; raddr = '0;
    c_write = 1'b0; c_waddr = '0; c_datain = '0; c_read = 1'b0; c_raddr = '0;
    d_write = 1'b0; d_waddr = '0; d_datain = '0; d_read = 1'b0; d_raddr = '0;

    repeat (2) step();
    check("reset_rvalid", a_rvalid, 1'b0);
    check("reset_dataout", a_dataout, 4'h0);
    check("reset_busy", a_busy, 1'b1);
    check("reset_busy_c", c_busy, 1'b1);
    check("reset_busy_noinit", d_busy, 1'b0);
    check("reset_rvalid_c", c_rvalid, 1'b0);

    // First release: attempt a write and reads during the sweep, then reset mid-clear.
    rst_n = 1'b1;
    write = 1'b1; waddr = 4'd2; datain = 4'h9;
    read = 1'b1; raddr = 4'd5;
    for (int i = 0; i < 5; i++) begin
      step();
      check("midclear_busy", a_busy, 1'b1);
      check("midclear_rvalid", a_rvalid, 1'b0);
    end
    rst_n = 1'b0;
    #1;
    check("rst_again_busy", a_busy, 1'b1);
    check("rst_again_rvalid", a_rvalid, 1'b0);
    step();

    // Second release: measure the full sweep; INIT_ZERO=0 build writes on the first edge.
    d_write = 1'b1; d_waddr = 4'd9; d_datain = 4'hB;
    rst_n = 1'b1;
    n = 0;
    while (a_busy && n < 100) begin
      step();
      n++;
      check("clear_rvalid", a_rvalid, 1'b0);
      check("clear_dataout", a_dataout, 4'h0);
      if (n == 1) begin
        check("noinit_busy", d_busy, 1'b0);
        d_write = 1'b0; d_read = 1'b1; d_raddr = 4'd9;
      end else if (n == 2) begin
        check("noinit_rvalid", d_rvalid, 1'b1);
        check("noinit_data", d_dataout, 4'hB);
        d_read = 1'b0;
      end
    end
    check("clear_cycles", n, 16);
    write = 1'b0;
    step();
    check("first_read_rvalid", a_rvalid, 1'b1);
    check("first_read_data", a_dataout, 4'h0);
    read = 1'b0;

    // Table-driven vectors against the latency-1 builds.
    for (int i = 0; i < 14; i++) begin
      write = vec[i].wr; waddr = vec[i].wa; datain = vec[i].wd;
      read = vec[i].rd; raddr = vec[i].ra;
      step();
      check($sformatf("vec%0d_rvalid_a", i), a_rvalid, vec[i].ev);
      check($sformatf("vec%0d_data_a", i), a_dataout, vec[i].ed_a);
      check($sformatf("vec%0d_rvalid_b", i), b_rvalid, vec[i].ev);
      check($sformatf("vec%0d_data_b", i), b_dataout, vec[i].ed_b);
    end
    write = 1'b0; read = 1'b0;

    // Latency-2 build: wait out its 64-word sweep.
    n = 0;
    while (c_busy && n < 100) begin
      step();
      n++;
    end
    check("c_clear_done", c_busy, 1'b0);

    c_write = 1'b1; c_waddr = 6'd40; c_datain = 8'hA5;
    step();
    c_write = 1'b0; c_read = 1'b1; c_raddr = 6'd40;
    step();
    check("lat2_edge1_rvalid", c_rvalid, 1'b0);
    check("lat2_edge1_data", c_dataout, 8'h00);
    c_read = 1'b0;
    step();
    check("lat2_edge2_rvalid", c_rvalid, 1'b1);
    check("lat2_edge2_data", c_dataout, 8'hA5);
    c_read = 1'b1; c_raddr = 6'd63;
    step();
    check("lat2_idle_rvalid", c_rvalid, 1'b0);
    check("lat2_idle_data", c_dataout, 8'h00);
    c_read = 1'b0;
    step();
    check("lat2_cleared_rvalid", c_rvalid, 1'b1);
    check("lat2_cleared_data", c_dataout, 8'h00);

    c_write = 1'b1; c_waddr = 6'd41; c_datain = 8'h3C;
    step();
    c_waddr = 6'd42; c_datain = 8'h7E;
    step();
    c_write = 1'b0;

    s_rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    s_ra = '{6'd40, 6'd41, 6'd42, 6'd0, 6'd0};
    s_ev = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    s_ed = '{8'h00, 8'hA5, 8'h3C, 8'h7E, 8'h00};
    for (int i = 0; i < 5; i++) begin
      c_read = s_rd[i]; c_raddr = s_ra[i];
      step();
      check($sformatf("stream%0d_rvalid", i), c_rvalid, s_ev[i]);
      check($sformatf("stream%0d_data", i), c_dataout, s_ed[i]);
    end

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
